// File: rtl/edge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | edge_pkg : shared types for the pulse <-> level signalling path  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    HOLD_PEND = 2'd2
  } state_e;

  localparam logic LVL_LOW  = 1'b0;
  localparam logic LVL_HIGH = 1'b1;

  // Error classes as seen by edge_detector-side monitors.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SEQ  = 2'd1,
    ERR_OVF  = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    EV_NONE      = 2'd0,
    EV_LEGAL     = 2'd1,
    EV_REDUNDANT = 2'd2,
    EV_BOTH      = 2'd3
  } ev_e;

  function automatic ev_e classify_event(input logic p, input logic n, input logic lvl);
    if (p && n) return EV_BOTH;
    if (p)      return (lvl == LVL_LOW)  ? EV_LEGAL : EV_REDUNDANT;
    if (n)      return (lvl == LVL_HIGH) ? EV_LEGAL : EV_REDUNDANT;
    return EV_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hold_timer : loadable saturating down-counter for hold windows   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o,
  output logic             active_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);
  // Last busy cycle: the counter reaches zero on the next edge.
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/edge_to_level.sv
`default_nettype none
// +------------------------------------------------------------------+
// | edge_to_level : rebuilds a level from p/n edge pulses with a     |
// | minimum hold time, one-deep event buffer and sticky error flags. |
// | Optional macro HIGH_WIDTH_MEAS_EN adds high-pulse width measure. |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module edge_to_level
  import edge_pkg::*;
#(
  parameter int   MIN_HOLD   = 3,
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in_p,
  input  logic             pulse_in_n,
  input  logic             clr_err,
  output logic             sig_out,
  output logic             busy,
  output logic             pend,
  output logic             err_seq,
  output logic             err_ovf
`ifdef HIGH_WIDTH_MEAS_EN
  ,
  output logic [CNT_W-1:0] high_width,
  output logic             high_width_vld
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);
  localparam bit               HAS_HOLD  = (MIN_HOLD > 1);

  if ((MIN_HOLD < 1) || ((64'd1 << CNT_W) <= 64'(MIN_HOLD))) begin : g_param_check
    $error("edge_to_level: MIN_HOLD must be >= 1 and below 2**CNT_W");
  end

  state_e state_q, state_d;
  logic   sig_q, sig_d;
  logic   pl_q, pl_d;
  logic   eseq_q, eseq_d;
  logic   eovf_q, eovf_d;
  logic   t_load, t_expire, t_active;
  logic   lvl_eff;
  ev_e    ev;
  err_e   err_type;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (t_load),
    .load_val_i (HOLD_LOAD),
    .expire_o   (t_expire),
    .active_o   (t_active)
  );

  // In HOLD_PEND the pending level is both the effective level and the
  // level sig_out takes when the slot drains, so one classification serves.
  assign lvl_eff = (state_q == HOLD_PEND) ? pl_q : sig_q;
  assign ev      = classify_event(pulse_in_p, pulse_in_n, lvl_eff);

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    pl_d     = pl_q;
    t_load   = 1'b0;
    err_type = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (ev == EV_LEGAL) begin
          sig_d = pulse_in_p ? LVL_HIGH : LVL_LOW;
          if (HAS_HOLD) begin
            t_load  = 1'b1;
            state_d = HOLD;
          end
        end else if (ev != EV_NONE) begin
          err_type = ERR_SEQ;
        end
      end
      HOLD: begin
        if (t_expire) state_d = IDLE;
        if (ev == EV_LEGAL) begin
          pl_d    = pulse_in_p ? LVL_HIGH : LVL_LOW;
          state_d = HOLD_PEND;
        end else if (ev != EV_NONE) begin
          err_type = ERR_SEQ;
        end
      end
      HOLD_PEND: begin
        if (!t_active) begin
          sig_d   = pl_q;
          pl_d    = LVL_LOW;
          t_load  = 1'b1;
          state_d = HOLD;
          if (ev == EV_LEGAL) begin
            pl_d    = pulse_in_p ? LVL_HIGH : LVL_LOW;
            state_d = HOLD_PEND;
          end else if (ev != EV_NONE) begin
            err_type = ERR_SEQ;
          end
        end else if (ev == EV_BOTH) begin
          err_type = ERR_SEQ;
        end else if (ev != EV_NONE) begin
          err_type = ERR_OVF;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh error outranks a simultaneous clear.
    eseq_d = (eseq_q & ~clr_err) | (err_type == ERR_SEQ);
    eovf_d = (eovf_q & ~clr_err) | (err_type == ERR_OVF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= INIT_LEVEL;
      pl_q    <= LVL_LOW;
      eseq_q  <= 1'b0;
      eovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      pl_q    <= pl_d;
      eseq_q  <= eseq_d;
      eovf_q  <= eovf_d;
    end
  end

  assign sig_out = sig_q;
  assign busy    = t_active;
  assign pend    = (state_q == HOLD_PEND);
  assign err_seq = eseq_q;
  assign err_ovf = eovf_q;

`ifdef HIGH_WIDTH_MEAS_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hw_q, hw_d;
  logic             hv_q, hv_d;
  logic [CNT_W-1:0] hcnt_inc;

  assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + 1'b1;

  always_comb begin
    hcnt_d = hcnt_q;
    hw_d   = hw_q;
    hv_d   = 1'b0;
    if (sig_q == LVL_HIGH) begin
      if (sig_d == LVL_LOW) begin
        hw_d   = hcnt_inc;
        hv_d   = 1'b1;
        hcnt_d = '0;
      end else begin
        hcnt_d = hcnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      hw_q   <= '0;
      hv_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hw_q   <= hw_d;
      hv_q   <= hv_d;
    end
  end

  assign high_width     = hw_q;
  assign high_width_vld = hv_q;
`endif

endmodule
`default_nettype wire
